// File: rtl/id_ex_if.sv
// Decode-to-execute bundle: the upstream side drives stall/flush and the id_* fields,
// and the pipe register drives the ex_* fields, the delay-slot feedback and the counters.
interface id_ex_if #(
    parameter int DATA_W    = 16,
    parameter int ALUOP_W   = 8,
    parameter int ALUSEL_W  = 3,
    parameter int REGADDR_W = 4,
    parameter int STALL_W   = 6,
    parameter int CNT_W     = 16
);
    logic [STALL_W-1:0]   stall;
    logic                 flush;
    logic                 id_valid;
    logic [ALUOP_W-1:0]   id_aluop;
    logic [ALUSEL_W-1:0]  id_alusel;
    logic [DATA_W-1:0]    id_reg1;
    logic [DATA_W-1:0]    id_reg2;
    logic [REGADDR_W-1:0] id_wd;
    logic                 id_wreg;
    logic                 id_flag_upd;
    logic                 id_is_in_delayslot;
    logic [DATA_W-1:0]    id_link_address;
    logic                 next_inst_in_delayslot_i;

    logic                 ex_valid;
    logic [ALUOP_W-1:0]   ex_aluop;
    logic [ALUSEL_W-1:0]  ex_alusel;
    logic [DATA_W-1:0]    ex_reg1;
    logic [DATA_W-1:0]    ex_reg2;
    logic [REGADDR_W-1:0] ex_wd;
    logic                 ex_wreg;
    logic                 ex_flag_upd;
    logic                 ex_is_in_delayslot;
    logic [DATA_W-1:0]    ex_link_address;
    logic                 is_in_delayslot_o;
    logic [CNT_W-1:0]     bubble_cnt;
    logic [CNT_W-1:0]     hold_cnt;

    modport master (
        output stall, flush, id_valid, id_aluop, id_alusel, id_reg1, id_reg2, id_wd,
               id_wreg, id_flag_upd, id_is_in_delayslot, id_link_address,
               next_inst_in_delayslot_i,
        input  ex_valid, ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg,
               ex_flag_upd, ex_is_in_delayslot, ex_link_address, is_in_delayslot_o,
               bubble_cnt, hold_cnt
    );

    modport slave (
        input  stall, flush, id_valid, id_aluop, id_alusel, id_reg1, id_reg2, id_wd,
               id_wreg, id_flag_upd, id_is_in_delayslot, id_link_address,
               next_inst_in_delayslot_i,
        output ex_valid, ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg,
               ex_flag_upd, ex_is_in_delayslot, ex_link_address, is_in_delayslot_o,
               bubble_cnt, hold_cnt
    );
endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with valid bit, flush, clean bubble insertion and
// saturating bubble/hold event counters. Priority per edge: reset, flush, hold, bubble, advance.
module id_ex_pipe #(
    parameter int DATA_W     = 16,
    parameter int ALUOP_W    = 8,
    parameter int ALUSEL_W   = 3,
    parameter int REGADDR_W  = 4,
    parameter int STALL_W    = 6,
    parameter int STAGE      = 2,
    parameter int CNT_W      = 16,
    parameter int CLEAR_DATA = 1
) (
    input logic   clk,
    input logic   rst,
    id_ex_if.slave bus
);
    logic                 valid_q, valid_d;
    logic [ALUOP_W-1:0]   aluop_q, aluop_d;
    logic [ALUSEL_W-1:0]  alusel_q, alusel_d;
    logic [DATA_W-1:0]    reg1_q, reg1_d;
    logic [DATA_W-1:0]    reg2_q, reg2_d;
    logic [REGADDR_W-1:0] wd_q, wd_d;
    logic                 wreg_q, wreg_d;
    logic                 flag_q, flag_d;
    logic                 ds_q, ds_d;
    logic [DATA_W-1:0]    link_q, link_d;
    logic                 next_ds_q, next_ds_d;
    logic [CNT_W-1:0]     bub_q, bub_d;
    logic [CNT_W-1:0]     hold_q, hold_d;

    logic up, dn, kill, advance, stall_unused;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign up           = bus.stall[STAGE];
    assign dn           = bus.stall[STAGE+1];
    assign stall_unused = ^bus.stall;
    // A downstream stall dominates, so the illegal up=0/dn=1 pattern holds EX.
    assign kill    = bus.flush || (up && !dn);
    assign advance = !bus.flush && !up && !dn;

    always_comb begin
        valid_d   = valid_q;
        aluop_d   = aluop_q;
        alusel_d  = alusel_q;
        reg1_d    = reg1_q;
        reg2_d    = reg2_q;
        wd_d      = wd_q;
        wreg_d    = wreg_q;
        flag_d    = flag_q;
        ds_d      = ds_q;
        link_d    = link_q;
        next_ds_d = next_ds_q;
        bub_d     = bub_q;
        hold_d    = hold_q;
        if (kill) begin
            valid_d  = 1'b0;
            aluop_d  = '0;
            alusel_d = '0;
            wd_d     = '0;
            wreg_d   = 1'b0;
            flag_d   = 1'b0;
            ds_d     = 1'b0;
            if (CLEAR_DATA != 0) begin
                reg1_d = '0;
                reg2_d = '0;
                link_d = '0;
            end
            // A bubble leaves the instruction waiting in ID, so its delay-slot flag stays.
            if (bus.flush) next_ds_d = 1'b0;
            else           bub_d     = sat_inc(bub_q);
        end else if (advance) begin
            valid_d   = bus.id_valid;
            aluop_d   = bus.id_aluop;
            alusel_d  = bus.id_alusel;
            reg1_d    = bus.id_reg1;
            reg2_d    = bus.id_reg2;
            wd_d      = bus.id_wd;
            wreg_d    = bus.id_wreg;
            flag_d    = bus.id_flag_upd;
            ds_d      = bus.id_is_in_delayslot;
            link_d    = bus.id_link_address;
            next_ds_d = bus.next_inst_in_delayslot_i;
        end else begin
            hold_d = sat_inc(hold_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            aluop_q   <= '0;
            alusel_q  <= '0;
            reg1_q    <= '0;
            reg2_q    <= '0;
            wd_q      <= '0;
            wreg_q    <= 1'b0;
            flag_q    <= 1'b0;
            ds_q      <= 1'b0;
            link_q    <= '0;
            next_ds_q <= 1'b0;
            bub_q     <= '0;
            hold_q    <= '0;
        end else begin
            valid_q   <= valid_d;
            aluop_q   <= aluop_d;
            alusel_q  <= alusel_d;
            reg1_q    <= reg1_d;
            reg2_q    <= reg2_d;
            wd_q      <= wd_d;
            wreg_q    <= wreg_d;
            flag_q    <= flag_d;
            ds_q      <= ds_d;
            link_q    <= link_d;
            next_ds_q <= next_ds_d;
            bub_q     <= bub_d;
            hold_q    <= hold_d;
        end
    end

    assign bus.ex_valid           = valid_q;
    assign bus.ex_aluop           = aluop_q;
    assign bus.ex_alusel          = alusel_q;
    assign bus.ex_reg1            = reg1_q;
    assign bus.ex_reg2            = reg2_q;
    assign bus.ex_wd              = wd_q;
    assign bus.ex_wreg            = wreg_q;
    assign bus.ex_flag_upd        = flag_q;
    assign bus.ex_is_in_delayslot = ds_q;
    assign bus.ex_link_address    = link_q;
    assign bus.is_in_delayslot_o  = next_ds_q;
    assign bus.bubble_cnt         = bub_q;
    assign bus.hold_cnt           = hold_q;
endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- Parametrised ID/EX pipeline register for the 5-stage core. It is the next-generation decode-to-execute latch.
- Carries ALU op/sel, operands, destination, flag-update and delay-slot/link fields from decode to execute.
- Adds an explicit valid bit, a flush input, fully consistent bubble insertion (every control field cleared) and saturating stall/bubble event counters.
- Widths and the stall-vector position are parameters, so the same block can serve other stage boundaries.

Parameters:
DATA_W, 16, operand and link-address width
ALUOP_W, 8, ALU operation code width
ALUSEL_W, 3, ALU result-select width
REGADDR_W, 4, register-file address width
STALL_W, 6, width of global stall vector
STAGE, 2, stall bit index of the upstream (ID) stage; STAGE+1 is the downstream (EX) stage; STAGE+1 must be < STALL_W
CNT_W, 16, event counter width
CLEAR_DATA, 1, 1: bubble/flush also zero ex_reg1/ex_reg2/ex_link_address; 0: those data fields hold (power saving)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
stall  in  STALL_W  global stall vector, 1 = stage stopped
flush  in  1  kill the instruction entering EX (exception/redirect)
id_valid  in  1  ID holds a real instruction
id_aluop  in  ALUOP_W  decoded ALU op
id_alusel  in  ALUSEL_W  decoded result select
id_reg1  in  DATA_W  operand 1
id_reg2  in  DATA_W  operand 2
id_wd  in  REGADDR_W  destination register
id_wreg  in  1  destination write enable
id_flag_upd  in  1  instruction updates flags
id_is_in_delayslot  in  1  ID instruction sits in a delay slot
id_link_address  in  DATA_W  return address for branch-and-link
next_inst_in_delayslot_i  in  1  next instruction entering ID is a delay slot
ex_valid  out  1  EX holds a real instruction
ex_aluop  out  ALUOP_W
ex_alusel  out  ALUSEL_W
ex_reg1  out  DATA_W
ex_reg2  out  DATA_W
ex_wd  out  REGADDR_W
ex_wreg  out  1
ex_flag_upd  out  1
ex_is_in_delayslot  out  1
ex_link_address  out  DATA_W
is_in_delayslot_o  out  1  fed back to ID: current ID instruction is a delay slot
bubble_cnt  out  CNT_W  count of bubble cycles inserted
hold_cnt  out  CNT_W  count of hold cycles (EX stalled)

Behaviour:
- Let up = stall[STAGE] and dn = stall[STAGE+1].
- Each edge performs exactly one action, in this priority order:
  1. RESET (rst=1): all outputs 0, i.e. NOP op 0, sel 0, reg addr 0, wreg/flag_upd/valid/delay-slot 0, data 0. Both counters 0.
  2. FLUSH (flush=1): ex_valid, ex_aluop, ex_alusel, ex_wd, ex_wreg, ex_flag_upd, ex_is_in_delayslot all cleared; is_in_delayslot_o cleared. Data fields cleared if CLEAR_DATA=1, else held. Counters unchanged. Flush overrides any stall combination.
  3. BUBBLE (up=1, dn=0): same clears as FLUSH, except is_in_delayslot_o holds, because the instruction is still waiting in ID. bubble_cnt += 1.
  4. ADVANCE (up=0, dn=0): every ex_* field loads its id_* counterpart; ex_valid <= id_valid; is_in_delayslot_o <= next_inst_in_delayslot_i.
  5. HOLD (dn=1, regardless of up): all outputs hold. hold_cnt += 1.
- Illegal stall pattern up=0, dn=1 is treated as HOLD (downstream stall dominates), so no instruction is overwritten.
- Counters saturate at all-ones; no wrap.
- Latency: 1 cycle ID to EX on ADVANCE. No combinational path from inputs to outputs.
- Reset mid-stall or mid-flush: reset wins; state after reset is identical to power-up reset.
- id_valid=0 with ADVANCE: fields are still loaded verbatim and ex_valid=0. Downstream must qualify on ex_valid.

Test Plan:
- rst=1 for 2 cycles with all inputs nonzero (aluop=8'hA5, reg1=16'h1234, flag_upd=1) -> every output 0, both counters 0.
- stall=0, id_valid=1, aluop=8'h21, reg1=16'h00FF, wd=4'h3, wreg=1, link=16'h0040, next_inst_in_delayslot_i=1 -> after one edge ex_* match; ex_valid=1; is_in_delayslot_o=1.
- With EX holding the above, stall=6'b000100 for 3 cycles -> ex_valid=0, ex_wreg=0, ex_flag_upd=0, ex_is_in_delayslot=0, reg1=0 (CLEAR_DATA=1); is_in_delayslot_o stays 1; bubble_cnt=3.
- stall=6'b001100 for 4 cycles with changing id_* -> outputs frozen; hold_cnt=4; bubble_cnt unchanged.
- flush=1 together with stall=6'b001100 -> flush wins: ex_valid=0, is_in_delayslot_o=0, counters unchanged. Repeat with CLEAR_DATA=0 -> ex_reg1 retains 16'h00FF.
- CNT_W=4: force 20 bubble cycles -> bubble_cnt saturates at 4'hF. Then rst -> 0.
